// File: rtl/dpi_int_pkg.sv
// -----------------------------------------------------------------------------
// dpi_int_pkg
// Shared types between the SynFull DPI trace interface and the ProNoC
// endpoint injectors.
//   req_t          : one injection request; .valid qualifies the record
//   deliver_t      : one delivery notification back to the trace side
//   sched_state_e  : run-control states of the injection scheduler
//   SCHED_QDEPTH   : default per-endpoint request FIFO depth
// -----------------------------------------------------------------------------
package dpi_int_pkg;

   localparam int SCHED_QDEPTH = 4;

   typedef struct packed {
      logic        valid;
      logic [15:0] id;
      logic [7:0]  dest;
      logic [7:0]  size;
   } req_t;

   typedef struct packed {
      logic        valid;
      logic [15:0] id;
      logic [7:0]  src;
   } deliver_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } sched_state_e;

endpackage

// File: rtl/synfull_req_fifo.sv
// -----------------------------------------------------------------------------
// synfull_req_fifo
// Single-lane req_t FIFO, depth QDEPTH (power of two, >= 2).
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : store data_i; ignored when full unless popping the same cycle
//   pop_i        : discard the head entry; ignored when empty
//   data_i       : request to store
//   head_o       : oldest stored request (meaningful only when not empty)
//   full_o       : QDEPTH entries stored
//   empty_o      : nothing stored
// -----------------------------------------------------------------------------
module synfull_req_fifo
   import dpi_int_pkg::*;
#(
   parameter int QDEPTH = SCHED_QDEPTH
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  logic pop_i,
   input  req_t data_i,
   output req_t head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   req_t        mem_q [QDEPTH];
   req_t        mem_d [QDEPTH];
   logic        empty_s;
   logic        full_s;
   logic        rd_s;
   logic        wr_s;

   assign empty_s = (wptr_q == rptr_q);
   assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign rd_s    = pop_i && !empty_s;
   // A pop frees the slot this cycle, so a push into a full FIFO is kept.
   assign wr_s    = push_i && (!full_s || rd_s);

   assign head_o  = mem_q[rptr_q[AW-1:0]];
   assign full_o  = full_s;
   assign empty_o = empty_s;

   // Next storage contents and pointer values.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (wr_s) begin
         mem_d[wptr_q[AW-1:0]] = data_i;
         wptr_d                = wptr_q + PTR_ONE;
      end else begin
         wptr_d = wptr_q;
      end
      if (rd_s) begin
         rptr_d = rptr_q + PTR_ONE;
      end else begin
         rptr_d = rptr_q;
      end
   end

   // Storage and pointer registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         mem_q  <= mem_d;
      end
   end

endmodule

// File: rtl/synfull_inject_sched.sv
// -----------------------------------------------------------------------------
// synfull_inject_sched
// Per-endpoint injection scheduler between the SynFull DPI trace side and the
// ProNoC injectors. Requests that cannot be injected immediately are queued in
// a per-endpoint FIFO and replayed in order; a run-control FSM walks the
// co-simulation through IDLE -> INIT -> RUN -> DRAIN -> DONE.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   go_i                : start request (level), sampled in IDLE and DONE
//   end_com_i           : trace finished
//   init_o              : DPI connection_init enable, high for INIT_CYCLES
//   start_com_o         : DPI startCom, high in RUN
//   syn_req_all_i       : per-endpoint trace requests
//   NE_ready_all_i      : per-endpoint injector ready
//   pronoc_req_all_o    : per-endpoint requests to the injectors
//   q_full_all_o        : per-endpoint FIFO full
//   q_empty_all_o       : per-endpoint FIFO empty
//   drop_cnt_all_o      : per-endpoint saturating dropped-request counters
//   state_o             : FSM state encoding
//   done_o              : high in DONE
//   timeout_o           : sticky, DRAIN ended by timeout
// -----------------------------------------------------------------------------
module synfull_inject_sched
   import dpi_int_pkg::*;
#(
   parameter int NE            = 4,
   parameter int QDEPTH        = SCHED_QDEPTH,
   parameter int INIT_CYCLES   = 3,
   parameter int DRAIN_TIMEOUT = 1024,
   parameter int CNTW          = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     go_i,
   input  logic                     end_com_i,
   output logic                     init_o,
   output logic                     start_com_o,
   input  req_t [NE-1:0]            syn_req_all_i,
   input  logic [NE-1:0]            NE_ready_all_i,
   output req_t [NE-1:0]            pronoc_req_all_o,
   output logic [NE-1:0]            q_full_all_o,
   output logic [NE-1:0]            q_empty_all_o,
   output logic [NE-1:0][CNTW-1:0]  drop_cnt_all_o,
   output logic [2:0]               state_o,
   output logic                     done_o,
   output logic                     timeout_o
);

   localparam int ICW = $clog2(INIT_CYCLES + 1);
   localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [ICW-1:0]  INIT_LOAD  = ICW'(INIT_CYCLES - 1);
   localparam logic [ICW-1:0]  ICNT_ONE   = ICW'(1);
   localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);
   localparam logic [DCW-1:0]  DCNT_ONE   = DCW'(1);
   localparam logic [CNTW-1:0] DROP_ONE   = CNTW'(1);
   localparam logic [CNTW-1:0] DROP_MAX   = {CNTW{1'b1}};

   sched_state_e              state_q, state_d;
   logic [ICW-1:0]            init_cnt_q, init_cnt_d;
   logic [DCW-1:0]            drain_cnt_q, drain_cnt_d;
   logic                      timeout_q, timeout_d;
   logic                      init_q, init_d;
   logic                      start_q, start_d;
   logic                      done_q, done_d;
   logic [NE-1:0][CNTW-1:0]   drop_cnt_q, drop_cnt_d;

   req_t [NE-1:0]             fifo_head_s;
   logic [NE-1:0]             fifo_full_s;
   logic [NE-1:0]             fifo_empty_s;
   logic [NE-1:0]             push_s;
   logic [NE-1:0]             pop_s;
   logic [NE-1:0]             accept_s;
   logic [NE-1:0]             drop_s;
   logic                      run_s;
   logic                      all_empty_s;

   assign run_s       = (state_q == RUN);
   assign all_empty_s = &fifo_empty_s;

   for (genvar k = 0; k < NE; k++) begin : g_lane
      synfull_req_fifo #(
         .QDEPTH (QDEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (push_s[k]),
         .pop_i   (pop_s[k]),
         .data_i  (syn_req_all_i[k]),
         .head_o  (fifo_head_s[k]),
         .full_o  (fifo_full_s[k]),
         .empty_o (fifo_empty_s[k])
      );
   end

   // Per-lane bypass/queue steering, output masking and drop counting.
   always_comb begin
      pronoc_req_all_o = '0;
      accept_s         = '0;
      push_s           = '0;
      pop_s            = '0;
      drop_s           = '0;
      drop_cnt_d       = drop_cnt_q;
      for (int k = 0; k < NE; k++) begin
         accept_s[k] = syn_req_all_i[k].valid && run_s;
         pop_s[k]    = !fifo_empty_s[k] && NE_ready_all_i[k];
         // An empty FIFO with a ready endpoint passes the input straight through.
         push_s[k]   = accept_s[k] && !(fifo_empty_s[k] && NE_ready_all_i[k]);
         drop_s[k]   = (syn_req_all_i[k].valid && !run_s) ||
                       (push_s[k] && fifo_full_s[k] && !pop_s[k]);
         if (fifo_empty_s[k]) begin
            pronoc_req_all_o[k]       = syn_req_all_i[k];
            pronoc_req_all_o[k].valid = accept_s[k] && NE_ready_all_i[k];
         end else begin
            pronoc_req_all_o[k]       = fifo_head_s[k];
            pronoc_req_all_o[k].valid = fifo_head_s[k].valid && NE_ready_all_i[k];
         end
         if (drop_s[k] && (drop_cnt_q[k] != DROP_MAX)) begin
            drop_cnt_d[k] = drop_cnt_q[k] + DROP_ONE;
         end else begin
            drop_cnt_d[k] = drop_cnt_q[k];
         end
      end
   end

   // Run-control next state, cycle counters and registered status outputs.
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      drain_cnt_d = drain_cnt_q;
      timeout_d   = timeout_q;
      case (state_q)
         IDLE: begin
            if (go_i) begin
               state_d    = INIT;
               init_cnt_d = INIT_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         INIT: begin
            if (init_cnt_q == '0) begin
               state_d = RUN;
            end else begin
               init_cnt_d = init_cnt_q - ICNT_ONE;
            end
         end
         RUN: begin
            if (end_com_i) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            // Emptiness wins over a timeout that expires on the same cycle.
            if (all_empty_s) begin
               state_d = DONE;
            end else if (drain_cnt_q == DRAIN_LAST) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + DCNT_ONE;
            end
         end
         DONE: begin
            if (!go_i) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Status outputs are registered copies of the next-state decode, so they
      // line up with state_q without a combinational path from state_q.
      init_d  = (state_d == INIT);
      start_d = (state_d == RUN);
      done_d  = (state_d == DONE);
   end

   // State, counter and status registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         init_cnt_q  <= '0;
         drain_cnt_q <= '0;
         timeout_q   <= 1'b0;
         init_q      <= 1'b0;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         timeout_q   <= timeout_d;
         init_q      <= init_d;
         start_q     <= start_d;
         done_q      <= done_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign init_o         = init_q;
   assign start_com_o    = start_q;
   assign done_o         = done_q;
   assign timeout_o      = timeout_q;
   assign state_o        = state_q;
   assign q_full_all_o   = fifo_full_s;
   assign q_empty_all_o  = fifo_empty_s;
   assign drop_cnt_all_o = drop_cnt_q;

endmodule

// File: tb/tb_synfull_inject_sched.sv
// -----------------------------------------------------------------------------
// tb_synfull_inject_sched
// Directed, self-checking bench for synfull_inject_sched (NE=4, QDEPTH=4,
// INIT_CYCLES=3, DRAIN_TIMEOUT=1024). A table drives lane 1 through
// backpressure, full/drop and simultaneous push/pop; hand-written sequences
// cover reset, run-control sequencing, bypass, drain, timeout and reset mid-run.
// -----------------------------------------------------------------------------
module tb_synfull_inject_sched;
   import dpi_int_pkg::*;

   localparam int NE   = 4;
   localparam int CNTW = 16;
   localparam int DT   = 1024;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    go;
   logic                    end_com;
   logic                    init_w;
   logic                    start_w;
   req_t [NE-1:0]           syn;
   logic [NE-1:0]           rdy;
   req_t [NE-1:0]           pro;
   logic [NE-1:0]           qf;
   logic [NE-1:0]           qe;
   logic [NE-1:0][CNTW-1:0] drop;
   logic [2:0]              st;
   logic                    done_w;
   logic                    tmo_w;

   int n_tests = 0;
   int n_fail  = 0;

   synfull_inject_sched #(
      .NE            (NE),
      .QDEPTH        (4),
      .INIT_CYCLES   (3),
      .DRAIN_TIMEOUT (DT),
      .CNTW          (CNTW)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .go_i             (go),
      .end_com_i        (end_com),
      .init_o           (init_w),
      .start_com_o      (start_w),
      .syn_req_all_i    (syn),
      .NE_ready_all_i   (rdy),
      .pronoc_req_all_o (pro),
      .q_full_all_o     (qf),
      .q_empty_all_o    (qe),
      .drop_cnt_all_o   (drop),
      .state_o          (st),
      .done_o           (done_w),
      .timeout_o        (tmo_w)
   );

   always #5 clk = ~clk;

   // Lane-1 stimulus/expectation record; status fields are pre-edge values.
   typedef struct {
      logic        v;
      logic [15:0] id;
      logic        rdy;
      logic        ov;
      logic [15:0] oid;
      logic        full;
      logic        empty;
      logic [15:0] drop;
   } vec_t;

   vec_t tv [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] vld(input req_t [3:0] r);
      return {r[3].valid, r[2].valid, r[1].valid, r[0].valid};
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"}, {29'd0, st}, 32'd0);
      chk({tag, "_init"}, {31'd0, init_w}, 32'd0);
      chk({tag, "_start"}, {31'd0, start_w}, 32'd0);
      chk({tag, "_done"}, {31'd0, done_w}, 32'd0);
      chk({tag, "_timeout"}, {31'd0, tmo_w}, 32'd0);
      chk({tag, "_qempty"}, {28'd0, qe}, 32'h0000_000F);
      chk({tag, "_qfull"}, {28'd0, qf}, 32'd0);
      chk({tag, "_valid"}, {28'd0, vld(pro)}, 32'd0);
      for (int k = 0; k < NE; k++) begin
         chk({tag, "_drop"}, {16'd0, drop[k]}, 32'd0);
      end
   endtask

   task automatic wait_run(input string tag);
      int n;
      n = 0;
      while ((st != 3'd2) && (n < 20)) begin
         n++;
         tick();
      end
      chk({tag, "_reach_run"}, {29'd0, st}, 32'd2);
   endtask

   // Watchdog so a stuck design cannot hang the run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int n_init;

      //             v     id      rdy   ov    oid     full  empty drop
      tv[0]  = '{1'b1, 16'd1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd0};
      tv[1]  = '{1'b1, 16'd2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
      tv[2]  = '{1'b1, 16'd3, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
      tv[3]  = '{1'b1, 16'd4, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
      tv[4]  = '{1'b1, 16'd5, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0};
      tv[5]  = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd1};
      tv[6]  = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 16'd1};
      tv[7]  = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 16'd1};
      tv[8]  = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 16'd1};
      tv[9]  = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 16'd1};
      tv[10] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd9, 1'b0, 1'b0, 16'd1};
      tv[11] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 16'd1};
      tv[12] = '{1'b1, 16'd7, 1'b1, 1'b1, 16'd7, 1'b0, 1'b1, 16'd1};
      tv[13] = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 16'd1};

      rst     = 1'b1;
      go      = 1'b0;
      end_com = 1'b0;
      syn     = '0;
      rdy     = '1;
      repeat (3) tick();
      check_reset_values("reset");
      rst = 1'b0;
      tick();

      // A request outside RUN is dropped and counted, never forwarded.
      syn[0].valid = 1'b1;
      syn[0].id    = 16'd42;
      #1;
      chk("idle_no_forward", {31'd0, pro[0].valid}, 32'd0);
      tick();
      syn[0].valid = 1'b0;
      #1;
      chk("idle_drop_cnt0", {16'd0, drop[0]}, 32'd1);
      chk("idle_qempty0", {31'd0, qe[0]}, 32'd1);

      // Sequencing: IDLE -> INIT for exactly 3 cycles -> RUN.
      go = 1'b1;
      tick();
      chk("seq_state_init", {29'd0, st}, 32'd1);
      n_init = 0;
      n      = 0;
      while (!start_w && (n < 20)) begin
         if (init_w) n_init++;
         n++;
         tick();
      end
      chk("seq_init_cycles", n_init, 32'd3);
      chk("seq_state_run", {29'd0, st}, 32'd2);
      chk("seq_init_low", {31'd0, init_w}, 32'd0);
      chk("seq_start_high", {31'd0, start_w}, 32'd1);

      // Bypass on lane 2, same cycle, nothing stored.
      syn[2].valid = 1'b1;
      syn[2].id    = 16'd7;
      #1;
      chk("byp_valid", {31'd0, pro[2].valid}, 32'd1);
      chk("byp_id", {16'd0, pro[2].id}, 32'd7);
      chk("byp_qempty_same", {31'd0, qe[2]}, 32'd1);
      tick();
      syn[2].valid = 1'b0;
      #1;
      chk("byp_qempty_after", {31'd0, qe[2]}, 32'd1);
      chk("byp_valid_after", {31'd0, pro[2].valid}, 32'd0);

      // Table: lane 1 backpressure, full drop, push+pop while full, replay.
      for (int i = 0; i < 14; i++) begin
         syn[1].valid = tv[i].v;
         syn[1].id    = tv[i].id;
         rdy[1]       = tv[i].rdy;
         #1;
         chk($sformatf("tv%0d_ovalid", i), {31'd0, pro[1].valid}, {31'd0, tv[i].ov});
         if (tv[i].ov) begin
            chk($sformatf("tv%0d_oid", i), {16'd0, pro[1].id}, {16'd0, tv[i].oid});
         end
         chk($sformatf("tv%0d_full", i), {31'd0, qf[1]}, {31'd0, tv[i].full});
         chk($sformatf("tv%0d_empty", i), {31'd0, qe[1]}, {31'd0, tv[i].empty});
         chk($sformatf("tv%0d_drop", i), {16'd0, drop[1]}, {16'd0, tv[i].drop});
         tick();
      end
      syn[1].valid = 1'b0;
      rdy          = '1;

      // Drain: two entries on lane 0, endpoint ready on the end_com cycle.
      rdy[0]       = 1'b0;
      syn[0].valid = 1'b1;
      syn[0].id    = 16'd11;
      tick();
      syn[0].id    = 16'd12;
      tick();
      syn[0].valid = 1'b0;
      rdy[0]       = 1'b1;
      end_com      = 1'b1;
      #1;
      chk("drn_head_id", {16'd0, pro[0].id}, 32'd11);
      chk("drn_head_valid", {31'd0, pro[0].valid}, 32'd1);
      tick();
      end_com = 1'b0;
      #1;
      chk("drn_state", {29'd0, st}, 32'd3);
      chk("drn_start_low", {31'd0, start_w}, 32'd0);
      chk("drn_second_id", {16'd0, pro[0].id}, 32'd12);
      n = 0;
      while ((st == 3'd3) && (n < 50)) begin
         n++;
         tick();
      end
      chk("drn_cycles", n, 32'd2);
      chk("drn_state_done", {29'd0, st}, 32'd4);
      chk("drn_done", {31'd0, done_w}, 32'd1);
      chk("drn_timeout", {31'd0, tmo_w}, 32'd0);
      tick();
      chk("done_hold_go", {29'd0, st}, 32'd4);
      go = 1'b0;
      tick();
      chk("done_to_idle", {29'd0, st}, 32'd0);
      chk("idle_done_low", {31'd0, done_w}, 32'd0);

      // Timeout: lane 3 blocked for the whole drain window.
      go = 1'b1;
      tick();
      wait_run("tmo");
      rdy[3]       = 1'b0;
      syn[3].valid = 1'b1;
      syn[3].id    = 16'd20;
      end_com      = 1'b1;
      tick();
      syn[3].valid = 1'b0;
      end_com      = 1'b0;
      #1;
      chk("tmo_state_drain", {29'd0, st}, 32'd3);
      chk("tmo_last_accept", {31'd0, qe[3]}, 32'd0);
      n = 0;
      while ((st == 3'd3) && (n < 2000)) begin
         n++;
         tick();
      end
      chk("tmo_drain_cycles", n, DT);
      chk("tmo_done", {31'd0, done_w}, 32'd1);
      chk("tmo_flag", {31'd0, tmo_w}, 32'd1);
      chk("tmo_no_out_unready", {31'd0, pro[3].valid}, 32'd0);
      rdy[3] = 1'b1;
      #1;
      chk("done_drain_valid", {31'd0, pro[3].valid}, 32'd1);
      chk("done_drain_id", {16'd0, pro[3].id}, 32'd20);
      tick();
      chk("done_drain_empty", {31'd0, qe[3]}, 32'd1);
      go = 1'b0;
      tick();
      chk("tmo_idle", {29'd0, st}, 32'd0);
      chk("tmo_sticky", {31'd0, tmo_w}, 32'd1);
      chk("drop_hold", {16'd0, drop[1]}, 32'd1);

      // Reset in RUN with data queued on lane 2.
      go = 1'b1;
      tick();
      wait_run("rst");
      rdy[2]       = 1'b0;
      syn[2].valid = 1'b1;
      syn[2].id    = 16'd30;
      tick();
      syn[2].id    = 16'd31;
      tick();
      syn[2].valid = 1'b0;
      #1;
      chk("rst_pre_queued", {31'd0, qe[2]}, 32'd0);
      rst = 1'b1;
      go  = 1'b0;
      tick();
      rdy = '1;
      #1;
      check_reset_values("midrst");
      rst = 1'b0;
      tick();
      chk("post_rst_idle", {29'd0, st}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
